// File: rtl/mux_rr.sv
// N-channel arbiter feeding a single registered output beat.
// MODE 0 rotates priority after each grant; MODE 1 always favours the lowest index.
module mux_rr #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*WIDTH-1:0]     in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(N)-1:0]   out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int SW = $clog2(N);

  logic [N-1:0][WIDTH-1:0] ch_data;
  logic [SW-1:0]           ptr;
  logic [SW-1:0]           ptr_nxt;
  logic [SW-1:0]           gnt_idx;
  logic                    gnt_vld;
  logic                    load;
  logic [SW:0]             cand;

  assign ch_data = in_data;
  assign load    = !out_valid || out_ready;

  // Scan N candidates starting at ptr (or 0); the extra bit of cand absorbs
  // the wrap so ptr never needs to exceed N-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == 1) begin
        cand = (SW+1)'(k);
      end else begin
        cand = {1'b0, ptr} + (SW+1)'(k);
        if (cand >= (SW+1)'(N)) cand = cand - (SW+1)'(N);
      end
      if (!gnt_vld && in_valid[cand[SW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[SW-1:0];
      end
    end
  end

  assign ptr_nxt = (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++)
      in_ready[i] = load && gnt_vld && (gnt_idx == SW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= gnt_vld;
      if (gnt_vld) begin
        out_data <= ch_data[gnt_idx];
        out_sel  <= gnt_idx;
        ptr      <= ptr_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr.sv
// Directed bench for mux_rr: round-robin N=4, fixed-priority N=4, round-robin N=3.
module tb_mux_rr;
  typedef struct { int sel; int data; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0] a_in_data;  logic [3:0] a_in_valid, a_in_ready;
  logic [3:0]  a_out_data; logic [1:0] a_out_sel; logic a_out_valid, a_out_ready;
  logic [15:0] b_in_data;  logic [3:0] b_in_valid, b_in_ready;
  logic [3:0]  b_out_data; logic [1:0] b_out_sel; logic b_out_valid, b_out_ready;
  logic [11:0] c_in_data;  logic [2:0] c_in_valid, c_in_ready;
  logic [3:0]  c_out_data; logic [1:0] c_out_sel; logic c_out_valid, c_out_ready;

  mux_rr #(.WIDTH(4), .N(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_sel(a_out_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready));
  mux_rr #(.WIDTH(4), .N(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready));
  mux_rr #(.WIDTH(4), .N(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_sel(c_out_sel),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  int total = 0;
  int bad   = 0;
  exp_t qa[$], qb[$], qc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_a();
    exp_t e;
    total++;
    assert (qa.size() != 0) else begin bad++; $error("FAIL a_queue observed=empty expected=entry"); return; end
    e = qa.pop_front();
    chk("a_vld", a_out_valid, 1); chk("a_sel", a_out_sel, e.sel); chk("a_data", a_out_data, e.data);
  endtask

  task automatic pop_b();
    exp_t e;
    total++;
    assert (qb.size() != 0) else begin bad++; $error("FAIL b_queue observed=empty expected=entry"); return; end
    e = qb.pop_front();
    chk("b_vld", b_out_valid, 1); chk("b_sel", b_out_sel, e.sel); chk("b_data", b_out_data, e.data);
  endtask

  task automatic pop_c();
    exp_t e;
    total++;
    assert (qc.size() != 0) else begin bad++; $error("FAIL c_queue observed=empty expected=entry"); return; end
    e = qc.pop_front();
    chk("c_vld", c_out_valid, 1); chk("c_sel", c_out_sel, e.sel); chk("c_data", c_out_data, e.data);
  endtask

  initial begin
    // reset: outputs cleared, in_ready still combinational, transfer lost
    rst_n = 1'b0;
    a_in_data = 16'h3210; a_in_valid = 4'b0100; a_out_ready = 1'b1;
    b_in_data = 16'hBA98; b_in_valid = 4'b0000; b_out_ready = 1'b1;
    c_in_data = 12'h654;  c_in_valid = 3'b000;  c_out_ready = 1'b1;
    #1;
    chk("rst_a_vld", a_out_valid, 0); chk("rst_a_data", a_out_data, 0); chk("rst_a_sel", a_out_sel, 0);
    chk("rst_b_vld", b_out_valid, 0); chk("rst_c_vld", c_out_valid, 0);
    chk("rst_a_rdy", a_in_ready, 4'b0100);
    @(negedge clk);
    chk("rst_lost_vld", a_out_valid, 0); chk("rst_lost_data", a_out_data, 0);

    // all channels valid, continuous drain
    rst_n = 1'b1;
    a_in_valid = 4'hF; b_in_valid = 4'b1010; c_in_valid = 3'b111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("a_rdy", a_in_ready, 1 << (k % 4)); qa.push_back('{k % 4, k % 4});
      chk("b_rdy", b_in_ready, 4'b0010);      qb.push_back('{1, 9});
      chk("c_rdy", c_in_ready, 1 << (k % 3)); qc.push_back('{k % 3, 4 + k % 3});
      @(negedge clk);
      pop_a(); pop_b(); pop_c();
    end

    // load channel 2 with 4'hA then stall downstream
    a_in_valid = 4'b0100; a_in_data = 16'h3A10;
    b_in_valid = 4'b0000; c_in_valid = 3'b000;
    #1;
    chk("a_rdy_ch2", a_in_ready, 4'b0100); qa.push_back('{2, 4'hA});
    @(negedge clk);
    pop_a();
    chk("b_idle_vld", b_out_valid, 0); chk("c_idle_vld", c_out_valid, 0);
    chk("c_hold_sel", c_out_sel, 1);   chk("c_hold_data", c_out_data, 5);
    a_in_valid = 4'hF; a_out_ready = 1'b0;
    #1;
    chk("stall_rdy", a_in_ready, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_vld", a_out_valid, 1); chk("stall_sel", a_out_sel, 2);
      chk("stall_data", a_out_data, 4'hA); chk("stall_rdy", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    #1;
    chk("unstall_rdy", a_in_ready, 4'b1000); qa.push_back('{3, 3});
    @(negedge clk);
    pop_a();

    // single-cycle request on channel 1, then idle
    a_in_valid = 4'b0010;
    #1;
    chk("ch1_rdy", a_in_ready, 4'b0010); qa.push_back('{1, 1});
    @(negedge clk);
    pop_a();
    a_in_valid = 4'b0000;
    #1;
    chk("idle_rdy", a_in_ready, 0);
    @(negedge clk);
    chk("pulse_vld", a_out_valid, 0); chk("pulse_sel_hold", a_out_sel, 1); chk("pulse_data_hold", a_out_data, 1);
    a_in_valid = 4'hF;
    #1;
    chk("ptr2_rdy", a_in_ready, 4'b0100); qa.push_back('{2, 4'hA});
    @(negedge clk);
    pop_a();

    // asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("async_vld", a_out_valid, 0); chk("async_data", a_out_data, 0); chk("async_sel", a_out_sel, 0);
    chk("async_rdy", a_in_ready, 4'b0001);
    @(negedge clk);
    chk("async_lost_vld", a_out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", a_in_ready, 4'b0001); qa.push_back('{0, 0});
    @(negedge clk);
    pop_a();
    a_in_valid = 4'b0000;
    @(negedge clk);
    chk("drain_vld", a_out_valid, 0);
    chk("queue_empty", qa.size() + qb.size() + qc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
